// File: rtl/mix_columns_seq.sv
// mix_columns_seq: sequential AES MixColumns, COLS_PER_CYCLE columns per clock, valid/ready in and out.
// Define INV_MIXCOL_EN to add inv_in and the InvMixColumns datapath.
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
`ifdef INV_MIXCOL_EN
    input  logic         inv_in,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // Matrix row 0 coefficients, one CW-bit field per entry; bit k of a field selects the xtime^k term.
`ifdef INV_MIXCOL_EN
    localparam int CW = 4;
    localparam logic [15:0] FWD = 16'h2311;
    localparam logic [15:0] INV = 16'hebd9;
`else
    localparam int CW = 2;
    localparam logic [7:0] FWD = 8'b10_11_01_01;
    localparam logic [7:0] INV = FWD;
`endif
    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state, state_nxt;
    logic           armed;
    logic [1:0]     col_cnt;
    logic [127:0]   data, data_nxt;
    logic [6:0]     hi;
    logic           inv;
    logic           accept;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] b, input logic [CW-1:0] c);
        logic [7:0] p, m;
        p = 8'h00;
        m = b;
        for (int k = 0; k < CW; k++) begin
            p ^= c[k] ? m : 8'h00;
            m = xt(m);
        end
        return p;
    endfunction

    // Circulant matrix: output row i takes coefficient (k-i) mod 4 of row 0 for input row k.
    function automatic logic [31:0] mix_col(input logic [31:0] a, input logic iv);
        logic [31:0]   r;
        logic [1:0]    d;
        logic [CW-1:0] c;
        r = '0;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                d = 2'(k - i);
                c = iv ? INV[(3 - d) * CW +: CW] : FWD[(3 - d) * CW +: CW];
                r[31 - 8 * i -: 8] ^= gm(a[31 - 8 * k -: 8], c);
            end
        return r;
    endfunction

    assign accept    = in_valid && in_ready;
    assign state_out = data;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? BUSY : IDLE;
            BUSY:    state_nxt = (col_cnt == LAST) ? DONE : BUSY;
            DONE:    state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // in_ready stays low until the first edge after reset release.
    always_comb begin
        in_ready  = armed && state == IDLE;
        out_valid = state == DONE;
    end

    always_comb begin
        data_nxt = data;
        hi = '0;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            hi = {~(col_cnt + 2'(j)), 5'h1f};
            data_nxt[hi -: 32] = mix_col(data[hi -: 32], inv);
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            armed   <= 1'b0;
            col_cnt <= '0;
            data    <= '0;
        end else begin
            armed <= 1'b1;
            if (accept) begin
                data    <= state_in;
                col_cnt <= '0;
            end else if (state == BUSY) begin
                data    <= data_nxt;
                col_cnt <= col_cnt + STEP;
            end
        end

`ifdef INV_MIXCOL_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) inv <= 1'b0;
        else if (accept) inv <= inv_in;
`else
    assign inv = 1'b0;
`endif
endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq: directed checks of mix_columns_seq at 1, 2 and 4 columns per cycle against a GF(2^8) matrix model.
// Inverse checks are compiled in when INV_MIXCOL_EN is defined.
module tb_mix_columns_seq;
    logic         clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, inv_in = 0;
    logic [127:0] state_in = '0;
    logic [2:0]   ir, ov;
    logic [127:0] so [3];

    int           tests = 0, fails = 0, n_out = 0;
    logic [127:0] q [$];

    localparam logic [7:0] FM [16] = '{8'h02, 8'h03, 8'h01, 8'h01, 8'h01, 8'h02, 8'h03, 8'h01,
                                       8'h01, 8'h01, 8'h02, 8'h03, 8'h03, 8'h01, 8'h01, 8'h02};
    localparam logic [7:0] IM [16] = '{8'h0e, 8'h0b, 8'h0d, 8'h09, 8'h09, 8'h0e, 8'h0b, 8'h0d,
                                       8'h0d, 8'h09, 8'h0e, 8'h0b, 8'h0b, 8'h0d, 8'h09, 8'h0e};
    localparam logic [127:0] S2 = {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'h2d26314c};
    localparam logic [127:0] E2 = {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'h4d7ebdf8};
    localparam logic [127:0] LS = {32'hc6c6c6c6, 32'hd4d4d4d5, 32'hdb135345, 32'h01010101};
    localparam logic [127:0] LE = {32'hc6c6c6c6, 32'hd5d5d7d6, 32'h8e4da1bc, 32'h01010101};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .in_valid(in_valid),
            .in_ready(ir[g]),
            .state_in(state_in),
`ifdef INV_MIXCOL_EN
            .inv_in(inv_in),
`endif
            .out_valid(ov[g]),
            .out_ready(out_ready),
            .state_out(so[g])
        );
    end

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        p = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] mcol(logic [31:0] a, logic inv);
        logic [31:0] r;
        r = 0;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++)
                r[31 - 8 * i -: 8] ^= gmul(a[31 - 8 * k -: 8], inv ? IM[4 * i + k] : FM[4 * i + k]);
        return r;
    endfunction

    function automatic logic [127:0] mstate(logic [127:0] s, logic inv);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) r[127 - 32 * c -: 32] = mcol(s[127 - 32 * c -: 32], inv);
        return r;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(string nm);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    task automatic send(logic [127:0] s);
        int t = 0;
        while (ir[0] !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        if (ir[0] !== 1'b1) timeout("send_wait");
        state_in = s;
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic wait_out(string nm);
        int t = 0;
        while (ov[0] !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        if (ov[0] !== 1'b1) timeout(nm);
    endtask

    initial begin
        logic [127:0] hold, r, f;
        logic [127:0] s [3];
        int lat [3];
        int t, i, base;
        fork
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) q.delete();
                else begin
                    if (ov[0] && out_ready && q.size() > 0) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                    if (in_valid && ir[0]) q.push_back(mstate(state_in, inv_in));
                end
            end
            forever begin
                @(negedge clk);
                if (rst_n && ov[0]) begin
                    if (q.size() == 0) chk("unexpected_out_valid", ov[0], 0);
                    else begin
                        chk("model_out", so[0], q[0]);
                        chk("in_ready_while_done", ir[0], 0);
                    end
                end
            end
        join_none

        chk("pin_col0", mcol(32'hdb135345, 0), 32'h8e4da1bc);
        chk("pin_col1", mcol(32'hf20a225c, 0), 32'h9fdc589d);
        chk("pin_col3", mcol(32'h2d26314c, 0), 32'h4d7ebdf8);
        chk("pin_inv", mcol(32'h8e4da1bc, 1), 32'hdb135345);

        repeat (2) @(negedge clk);
        chk("reset_in_ready", ir, 0);
        chk("reset_out_valid", ov, 0);
        chk("reset_state_out", so[0], 0);
        rst_n = 1;
        #1 chk("in_ready_before_edge", ir[0], 0);
        @(negedge clk);
        chk("in_ready_after_release", ir[0], 1);

        out_ready = 1;
        send(S2);
        wait_out("vec_wait");
        chk("column_vectors", so[0], E2);
        @(negedge clk);

        send({$urandom, $urandom, $urandom, $urandom});
        @(negedge clk);
        #2 rst_n = 0;
        #1 chk("midbusy_rst_out_valid", ov, 0);
        chk("midbusy_rst_state_out", so[0], 0);
        chk("midbusy_rst_in_ready", ir, 0);
        @(negedge clk);
        rst_n = 1;
        send(S2);
        wait_out("after_rst_wait");
        chk("after_rst_vector", so[0], E2);
        @(negedge clk);

        out_ready = 0;
        t = 0;
        while (ir !== 3'b111 && t < 100) begin @(negedge clk); t++; end
        if (ir !== 3'b111) timeout("latency_idle");
        state_in = LS;
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        lat = '{-1, -1, -1};
        for (int k = 0; k <= 6; k++) begin
            for (int g = 0; g < 3; g++) if (ov[g] && lat[g] < 0) lat[g] = k;
            @(negedge clk);
        end
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("latency_n%0d", 1 << g), lat[g], 4 >> g);
            chk($sformatf("latency_data_n%0d", 1 << g), so[g], LE);
        end
        out_ready = 1;
        repeat (2) @(negedge clk);

        out_ready = 0;
        send({$urandom, $urandom, $urandom, $urandom});
        wait_out("bp_wait");
        hold = so[0];
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_state_stable", so[0], hold);
            chk("bp_out_valid", ov[0], 1);
            chk("bp_in_ready", ir[0], 0);
            in_valid = k[0];
            state_in = {$urandom, $urandom, $urandom, $urandom};
        end
        in_valid = 0;
        out_ready = 1;
        @(negedge clk);
        chk("bp_release", ov[0], 0);

        base = n_out;
        for (int k = 0; k < 3; k++) s[k] = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1;
        i = 0;
        t = 0;
        while (i < 3 && t < 100) begin
            if (ir[0]) begin state_in = s[i]; i++; end
            @(negedge clk);
            t++;
        end
        in_valid = 0;
        if (i < 3) timeout("b2b_accept");
        t = 0;
        while (n_out < base + 3 && t < 100) begin @(negedge clk); t++; end
        repeat (10) @(negedge clk);
        chk("b2b_count", n_out - base, 3);
        chk("b2b_queue_empty", q.size(), 0);

`ifdef INV_MIXCOL_EN
        inv_in = 1;
        send(E2);
        inv_in = 0;
        wait_out("inv_wait");
        chk("inv_vector", so[0], S2);
        @(negedge clk);
        r = {$urandom, $urandom, $urandom, $urandom};
        send(r);
        wait_out("fwd_wait");
        f = so[0];
        @(negedge clk);
        inv_in = 1;
        send(f);
        inv_in = 0;
        wait_out("roundtrip_wait");
        chk("roundtrip", so[0], r);
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
